// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle controller for one reg-to-reg ALU op
// over the shared 32-bit bus (Y/Z/HI/LO strobes, start/busy/done).
module alu_op_sequencer #(
  parameter int MD_WAIT = 4,
  parameter int OP_W    = 5
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic [OP_W-1:0] opcode,
  input  logic [3:0]      ra,
  input  logic [3:0]      rb,
  input  logic [3:0]      rc,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [OP_W-1:0] alu_op,
  output logic            gpr_out_en,
  output logic [3:0]      gpr_out_sel,
  output logic            c_out_en,
  output logic            y_in,
  output logic            z_in,
  output logic            zlo_out,
  output logic            zhi_out,
  output logic            gpr_in_en,
  output logic [3:0]      gpr_in_sel,
  output logic            lo_in,
  output logic            hi_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_Y,
    S_EXEC,
    S_WB_LO,
    S_WB_HI,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    C_BIN,
    C_UNI,
    C_MD,
    C_ILL
  } cls_t;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(12);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(14);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(15);
  localparam logic [OP_W-1:0] OP_DIV  = OP_W'(16);
  localparam logic [OP_W-1:0] OP_NEG  = OP_W'(17);
  localparam logic [OP_W-1:0] OP_NOT  = OP_W'(18);

  localparam logic [3:0] LAST = 4'(MD_WAIT - 1);

  function automatic cls_t classify(
    input logic [OP_W-1:0] op
  );
    cls_t c;
    c = C_ILL;
    unique case (1'b1)
      (op >= OP_ADD && op <= OP_ORI):
        c = C_BIN;
      (op == OP_MUL || op == OP_DIV):
        c = C_MD;
      (op == OP_NEG || op == OP_NOT):
        c = C_UNI;
      default:
        c = C_ILL;
    endcase
    return c;
  endfunction

  state_t          state;
  cls_t            cls_q;
  logic [OP_W-1:0] op_q;
  logic [3:0]      ra_q;
  logic [3:0]      rb_q;
  logic [3:0]      rc_q;
  logic [3:0]      cnt;

  logic            idle;
  cls_t            cur_cls;
  logic [OP_W-1:0] cur_op;
  logic [3:0]      cur_rb;
  logic [3:0]      cur_rc;
  logic            enter_exec;
  logic            ex_imm;
  logic [3:0]      ex_sel;
  logic            ex_z;
  logic            exec_last;

  // Operand view: live inputs while idle, latched fields once accepted
  always_comb begin
    idle     = (state == S_IDLE);
    cur_op   = idle ? opcode : op_q;
    cur_rb   = idle ? rb : rb_q;
    cur_rc   = idle ? rc : rc_q;
    cur_cls  = idle ? classify(opcode) : cls_q;
    enter_exec = (idle && start && cur_cls == C_UNI)
              || (state == S_LOAD_Y);
    ex_imm   = (cur_op >= OP_ADDI) && (cur_op <= OP_ORI);
    ex_sel   = (cur_cls == C_UNI) ? cur_rb : cur_rc;
    ex_z     = (cur_cls != C_MD) || (LAST == 4'd0);
    exec_last = (cls_q != C_MD) || (cnt == LAST);
  end

  // Sequencer FSM; every strobe is registered alongside the state
  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= S_IDLE;
      cls_q       <= C_BIN;
      op_q        <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      rc_q        <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      alu_op      <= '0;
      gpr_out_en  <= 1'b0;
      gpr_out_sel <= '0;
      c_out_en    <= 1'b0;
      y_in        <= 1'b0;
      z_in        <= 1'b0;
      zlo_out     <= 1'b0;
      zhi_out     <= 1'b0;
      gpr_in_en   <= 1'b0;
      gpr_in_sel  <= '0;
      lo_in       <= 1'b0;
      hi_in       <= 1'b0;
    end else begin
      done        <= 1'b0;
      alu_op      <= '0;
      gpr_out_en  <= 1'b0;
      gpr_out_sel <= '0;
      c_out_en    <= 1'b0;
      y_in        <= 1'b0;
      z_in        <= 1'b0;
      zlo_out     <= 1'b0;
      zhi_out     <= 1'b0;
      gpr_in_en   <= 1'b0;
      gpr_in_sel  <= '0;
      lo_in       <= 1'b0;
      hi_in       <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= opcode;
            ra_q  <= ra;
            rb_q  <= rb;
            rc_q  <= rc;
            cls_q <= cur_cls;
            busy  <= 1'b1;
            err   <= 1'b0;
            unique case (cur_cls)
              C_BIN, C_MD: begin
                state       <= S_LOAD_Y;
                gpr_out_en  <= 1'b1;
                gpr_out_sel <= rb;
                y_in        <= 1'b1;
              end
              C_UNI: begin
                state <= S_EXEC;
              end
              default: begin
                state <= S_DONE;
                done  <= 1'b1;
                err   <= 1'b1;
              end
            endcase
          end
        end

        S_LOAD_Y: begin
          state <= S_EXEC;
        end

        S_EXEC: begin
          if (exec_last) begin
            state   <= S_WB_LO;
            zlo_out <= 1'b1;
            if (cls_q == C_MD) begin
              lo_in <= 1'b1;
            end else begin
              gpr_in_en  <= 1'b1;
              gpr_in_sel <= ra_q;
            end
          end else begin
            cnt         <= cnt + 4'd1;
            alu_op      <= op_q;
            gpr_out_en  <= 1'b1;
            gpr_out_sel <= rc_q;
            z_in        <= (cnt + 4'd1 == LAST);
          end
        end

        S_WB_LO: begin
          if (cls_q == C_MD) begin
            state   <= S_WB_HI;
            zhi_out <= 1'b1;
            hi_in   <= 1'b1;
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end

        S_WB_HI: begin
          state <= S_DONE;
          done  <= 1'b1;
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (enter_exec) begin
        state       <= S_EXEC;
        cnt         <= '0;
        alu_op      <= cur_op;
        c_out_en    <= ex_imm;
        gpr_out_en  <= !ex_imm;
        gpr_out_sel <= ex_imm ? 4'd0 : ex_sel;
        z_in        <= ex_z;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed bench with a small bus/ALU/register
// model driven by the sequencer strobes.
module tb_alu_op_sequencer;

  logic        clk;
  logic        clr;
  logic        start;
  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        busy, done, err;
  logic [4:0]  alu_op;
  logic        gpr_out_en;
  logic [3:0]  gpr_out_sel;
  logic        c_out_en;
  logic        y_in, z_in;
  logic        zlo_out, zhi_out;
  logic        gpr_in_en;
  logic [3:0]  gpr_in_sel;
  logic        lo_in, hi_in;

  int checks;
  int failures;
  int strobe_cnt;
  int base;
  int lat;
  logic dp_init;

  logic [31:0] gpr [16];
  logic [31:0] y, lo, hi;
  logic [63:0] z;
  logic [31:0] bus;
  logic [63:0] c;
  logic [31:0] imm;
  logic [24:0] all_out;

  alu_op_sequencer #(
    .MD_WAIT(4),
    .OP_W(5)
  ) dut (
    .clk(clk),
    .clr(clr),
    .start(start),
    .opcode(opcode),
    .ra(ra),
    .rb(rb),
    .rc(rc),
    .busy(busy),
    .done(done),
    .err(err),
    .alu_op(alu_op),
    .gpr_out_en(gpr_out_en),
    .gpr_out_sel(gpr_out_sel),
    .c_out_en(c_out_en),
    .y_in(y_in),
    .z_in(z_in),
    .zlo_out(zlo_out),
    .zhi_out(zhi_out),
    .gpr_in_en(gpr_in_en),
    .gpr_in_sel(gpr_in_sel),
    .lo_in(lo_in),
    .hi_in(hi_in)
  );

  assign imm = 32'h30;
  assign all_out = {busy, done, err, alu_op,
                    gpr_out_en, gpr_out_sel,
                    c_out_en, y_in, z_in,
                    zlo_out, zhi_out,
                    gpr_in_en, gpr_in_sel,
                    lo_in, hi_in};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus multiplexer of the datapath
  always_comb begin
    bus = '0;
    if (gpr_out_en)   bus = gpr[gpr_out_sel];
    else if (c_out_en) bus = imm;
    else if (zlo_out)  bus = z[31:0];
    else if (zhi_out)  bus = z[63:32];
  end

  // ALU: Y is operand a, bus is operand b
  always_comb begin
    c = '0;
    case (alu_op)
      5'd3:  c = {32'd0, y + bus};
      5'd4:  c = {32'd0, y - bus};
      5'd5:  c = {32'd0, y & bus};
      5'd6:  c = {32'd0, y | bus};
      5'd12: c = {32'd0, y + bus};
      5'd13: c = {32'd0, y & bus};
      5'd14: c = {32'd0, y | bus};
      5'd15: c = {32'd0, y} * {32'd0, bus};
      5'd16: c = (bus == 0) ? 64'd0 : {y % bus, y / bus};
      5'd17: c = {32'd0, -bus};
      5'd18: c = {32'd0, ~bus};
      default: c = '0;
    endcase
  end

  // Datapath registers loaded by the sequencer strobes
  always @(posedge clk) begin
    if (dp_init) begin
      for (int i = 0; i < 16; i++) gpr[i] <= '0;
      gpr[1]  <= 32'd5;
      gpr[2]  <= 32'd7;
      gpr[4]  <= 32'd1;
      gpr[7]  <= 32'd100;
      gpr[8]  <= 32'd7;
      gpr[10] <= 32'h10000;
      gpr[11] <= 32'h10000;
      y  <= '0;
      z  <= '0;
      lo <= '0;
      hi <= '0;
    end else begin
      if (y_in)      y <= bus;
      if (z_in)      z <= c;
      if (gpr_in_en) gpr[gpr_in_sel] <= bus;
      if (lo_in)     lo <= bus;
      if (hi_in)     hi <= bus;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (done !== 1'b1 && n < 40);
  endtask

  // Load-strobe counter and single-bus-driver check every cycle
  always @(negedge clk) begin
    if (y_in | z_in | gpr_in_en | lo_in | hi_in)
      strobe_cnt++;
    if (!dp_init)
      chk("bus_onehot",
          64'($countones({gpr_out_en, c_out_en,
                          zlo_out, zhi_out}) <= 1),
          64'd1);
  end

  initial begin
    checks = 0;
    failures = 0;
    strobe_cnt = 0;
    dp_init = 1'b1;
    clr = 1'b1;
    start = 1'b0;
    opcode = '0;
    ra = '0;
    rb = '0;
    rc = '0;
    tick();
    tick();
    chk("reset_outputs", 64'(all_out), 64'd0);
    clr = 1'b0;
    dp_init = 1'b0;
    tick();
    chk("idle_busy", 64'(busy), 64'd0);

    // add r3 = r1 + r2
    opcode = 5'd3; ra = 4'd3; rb = 4'd1; rc = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    opcode = 5'd18; ra = 4'd0; rb = 4'd0; rc = 4'd0;
    chk("add_c1_y_in", 64'(y_in), 64'd1);
    chk("add_c1_sel", 64'(gpr_out_sel), 64'd1);
    chk("add_c1_busy", 64'(busy), 64'd1);
    chk("add_c1_alu_op", 64'(alu_op), 64'd0);
    tick();
    chk("add_c2_z_in", 64'(z_in), 64'd1);
    chk("add_c2_alu_op", 64'(alu_op), 64'd3);
    chk("add_c2_sel", 64'(gpr_out_sel), 64'd2);
    chk("add_c2_y_in", 64'(y_in), 64'd0);
    tick();
    chk("add_c3_gpr_in", 64'(gpr_in_en), 64'd1);
    chk("add_c3_in_sel", 64'(gpr_in_sel), 64'd3);
    chk("add_c3_zlo", 64'(zlo_out), 64'd1);
    chk("add_c3_alu_op", 64'(alu_op), 64'd0);
    tick();
    chk("add_c4_done", 64'(done), 64'd1);
    chk("add_c4_err", 64'(err), 64'd0);
    tick();
    chk("add_c5_done", 64'(done), 64'd0);
    chk("add_c5_busy", 64'(busy), 64'd0);
    chk("add_r3", 64'(gpr[3]), 64'd12);

    // mul r10 * r11
    opcode = 5'd15; ra = 4'd0; rb = 4'd10; rc = 4'd11;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mul_c1_y_in", 64'(y_in), 64'd1);
    for (int k = 2; k <= 5; k++) begin
      tick();
      chk("mul_exec_alu_op", 64'(alu_op), 64'd15);
      chk("mul_exec_sel", 64'(gpr_out_sel), 64'd11);
      chk("mul_exec_z_in", 64'(z_in), 64'(k == 5));
    end
    tick();
    chk("mul_c6_lo_in", 64'(lo_in), 64'd1);
    chk("mul_c6_zlo", 64'(zlo_out), 64'd1);
    chk("mul_c6_gpr_in", 64'(gpr_in_en), 64'd0);
    tick();
    chk("mul_c7_hi_in", 64'(hi_in), 64'd1);
    chk("mul_c7_zhi", 64'(zhi_out), 64'd1);
    tick();
    chk("mul_c8_done", 64'(done), 64'd1);
    tick();
    chk("mul_lo", 64'(lo), 64'd0);
    chk("mul_hi", 64'(hi), 64'd1);

    // neg r6 = -r4, with stray start pulses while busy
    opcode = 5'd17; ra = 4'd6; rb = 4'd4; rc = 4'd9;
    start = 1'b1;
    tick();
    opcode = 5'd3;
    chk("neg_c1_y_in", 64'(y_in), 64'd0);
    chk("neg_c1_z_in", 64'(z_in), 64'd1);
    chk("neg_c1_alu_op", 64'(alu_op), 64'd17);
    chk("neg_c1_sel", 64'(gpr_out_sel), 64'd4);
    tick();
    start = 1'b0;
    chk("neg_c2_gpr_in", 64'(gpr_in_en), 64'd1);
    chk("neg_c2_in_sel", 64'(gpr_in_sel), 64'd6);
    start = 1'b1;
    tick();
    chk("neg_c3_done", 64'(done), 64'd1);
    tick();
    start = 1'b0;
    chk("neg_c4_busy", 64'(busy), 64'd0);
    chk("neg_c4_y_in", 64'(y_in), 64'd0);
    chk("neg_r6", 64'(gpr[6]), 64'hFFFF_FFFF);

    // illegal opcodes: load and 10111
    base = strobe_cnt;
    opcode = 5'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ill0_done", 64'(done), 64'd1);
    chk("ill0_err", 64'(err), 64'd1);
    chk("ill0_busy", 64'(busy), 64'd1);
    tick();
    chk("ill0_idle", 64'({busy, done}), 64'd0);
    opcode = 5'b10111;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ill23_done", 64'(done), 64'd1);
    chk("ill23_err", 64'(err), 64'd1);
    tick();
    chk("ill_no_strobes", 64'(strobe_cnt - base), 64'd0);

    // div interrupted by clr during the EXEC wait
    opcode = 5'd16; ra = 4'd0; rb = 4'd7; rc = 4'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("div_err_cleared", 64'(err), 64'd0);
    tick();
    tick();
    chk("div_exec_alu_op", 64'(alu_op), 64'd16);
    chk("div_exec_z_in", 64'(z_in), 64'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_outputs", 64'(all_out), 64'd0);
    tick();
    chk("clr_stays_idle", 64'(all_out), 64'd0);
    chk("clr_lo_kept", 64'(lo), 64'd0);

    // add r12 = r7 + r8 after the abort
    opcode = 5'd3; ra = 4'd12; rb = 4'd7; rc = 4'd8;
    start = 1'b1;
    run_to_done(lat);
    start = 1'b0;
    chk("post_clr_lat", 64'(lat), 64'd4);
    chk("post_clr_err", 64'(err), 64'd0);
    tick();
    chk("post_clr_r12", 64'(gpr[12]), 64'd107);

    // back-to-back with start held: sub then ori
    opcode = 5'd4; ra = 4'd13; rb = 4'd1; rc = 4'd2;
    start = 1'b1;
    run_to_done(lat);
    chk("b2b_sub_lat", 64'(lat), 64'd4);
    tick();
    chk("b2b_gap_busy", 64'(busy), 64'd0);
    opcode = 5'd14; ra = 4'd14; rb = 4'd1; rc = 4'd0;
    tick();
    start = 1'b0;
    chk("b2b_ori_y_in", 64'(y_in), 64'd1);
    chk("b2b_ori_busy", 64'(busy), 64'd1);
    tick();
    chk("b2b_ori_c_out", 64'(c_out_en), 64'd1);
    chk("b2b_ori_gpr_out", 64'(gpr_out_en), 64'd0);
    chk("b2b_ori_alu_op", 64'(alu_op), 64'd14);
    tick();
    tick();
    chk("b2b_ori_done", 64'(done), 64'd1);
    tick();
    chk("b2b_r13", 64'(gpr[13]), 64'hFFFF_FFFE);
    chk("b2b_r14", 64'(gpr[14]), 64'h35);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
